counter_sched: RTL and testbench
================================

Name: counter_sched

Overview:
- Round-robin scheduler that shares one W-bit up-counter between N requesters.
- Each requester asks for a counting run of a programmed length. The block grants one requester at a time, runs the shared counter from 0 up to the latched length, pulses done, then rotates priority.
- Intended as the sequencing front-end for the counter examples and as a formal target with both safety properties (mutual exclusion) and liveness properties (eventual grant).

Parameters:
- N, 3: number of requesters, N >= 2.
- W, 10: counter and length width.
- IW, $clog2(N): requester index width (derived localparam, not overridable).

Ports:
- clk, input, 1: clock; all state updates on posedge.
- rst, input, 1: reset, asynchronous and active-low.
- req, input, N: per-requester request level; held high until done for that requester.
- len, input, N*W: per-requester run length; slice i is bits [i*W +: W]; sampled only at grant.
- gnt, output, N: one-hot grant; all zero when idle.
- busy, output, 1: high in RUN and DONE.
- count, output, W: shared counter value.
- done, output, 1: one-cycle pulse when a run completes.
- done_id, output, IW: index of the completed requester; valid while done is high.

Behaviour:
- Reset: while rst is low, asynchronously force state=IDLE, gnt=0, busy=0, count=0, done=0, done_id=0, priority pointer ptr=0, latched length=0.
- Reset mid-run: the run is discarded and no done is issued.
- State IDLE:
  - If any req bit is high, choose the first set bit scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - Next edge: gnt=onehot(winner), owner=winner, lat_len=len[winner], count=0, state=RUN.
  - Otherwise stay in IDLE.
- State RUN:
  - If req[owner] is low: abort. Next edge sets state=IDLE, gnt=0, count=0, ptr=owner+1 mod N, and done is not pulsed.
  - Else if count==lat_len: next edge sets state=DONE.
  - Else: count increments by 1 each cycle.
- State DONE (one cycle):
  - Outputs: done=1, done_id=owner, gnt still held, count=lat_len.
  - Next edge: state=IDLE, gnt=0, count=0, ptr=owner+1 mod N (wraps N-1 to 0).
- Latency:
  - For length L, gnt is high for L+2 cycles: L+1 cycles in RUN plus 1 cycle in DONE.
  - From req rising in IDLE to gnt is 1 cycle.
  - Back-to-back: after DONE there is one IDLE cycle before the next grant.
- Length 0: RUN lasts one cycle with count=0, then DONE.
- Length all-ones: count reaches {W{1'b1}} without wrapping. Count never exceeds lat_len and never wraps.
- Changes to len during RUN are ignored.
- A new req arriving during RUN waits; it is never granted mid-run.
- Requests that drop while waiting are never granted.
- Simultaneous requests: the round-robin order above decides. No starvation: a requester that holds req is granted within N-1 completed runs.
- Invariants:
  - gnt is one-hot or zero.
  - gnt != 0 exactly when busy.
  - done implies busy.
  - count == 0 in IDLE.

Optional Feature:
- Macro: COUNTER_SCHED_PROPS_EN.
- Defined: embedded concurrent properties are compiled in, all clocked on posedge clk and disabled while rst is low.
  - Safety: $onehot0(gnt); count <= lat_len; done -> gnt[done_id].
  - Assume: a req bit, once high, stays high until its own done.
  - Liveness: for each i, assert s_eventually(gnt[i]) whenever req[i] is high.
- Undefined: no properties are compiled in and the RTL is otherwise identical.

Decomposition:
- Package counter_sched_pkg holds:
  - state typedef enum {IDLE, RUN, DONE}.
  - Function rr_pick(req, ptr) returning the index and a valid flag.
- One sub-module, rr_arbiter: combinational round-robin picker over N bits with a ptr input. It is reusable by other schedulers.
- The FSM, counter and latch stay in counter_sched.

Test Plan (N=3, W=4):
- Reset then idle: rst low with req=3'b111 -> gnt=0, count=0, done=0. After rst rises, gnt=3'b001 on the first edge.
- Single run: req[1]=1, len[1]=4 -> gnt=3'b010 for 6 cycles; count goes 0,1,2,3,4,4; done=1 with done_id=1 in the 6th cycle.
- Round-robin fairness: req=3'b111 held, all lengths 0 -> grant order 0,1,2,0. Each done is followed by one IDLE cycle.
- Boundaries: len=0 gives RUN 1 cycle then done. len=4'hF gives count peaking at 4'hF with no wrap and done after 17 grant cycles.
- Abort: req[2] drops in RUN while count=2 -> gnt=0 next edge, no done, and ptr=0 so req[0] wins next.
- Reset mid-run: rst low while count=7 -> count=0, gnt=0, busy=0 immediately (asynchronous); no done pulse is ever seen.

Source files
------------

// File: rtl/counter_sched_pkg.sv
// Shared types and the round-robin pick function for counter_sched.
// Build option: COUNTER_SCHED_PROPS_EN compiles embedded properties into counter_sched.
package counter_sched_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int unsigned RR_MAXN = 32;

  typedef struct packed {
    logic       valid;
    logic [4:0] idx;
  } rr_pick_t;

  // First set bit of req[n-1:0], scanning from ptr upward and wrapping to 0.
  function automatic rr_pick_t rr_pick(input logic [RR_MAXN-1:0] req,
                                       input int unsigned n,
                                       input int unsigned ptr);
    rr_pick_t    p;
    int unsigned i;
    p = '0;
    for (int unsigned k = 0; k < RR_MAXN; k++) begin
      i = ptr + k;
      if (i >= n) i = i - n;
      if (k < n && !p.valid && req[i[4:0]]) begin
        p.valid = 1'b1;
        p.idx   = i[4:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// Combinational round-robin picker over N request bits (N <= 32), starting at ptr.
module rr_arbiter
  import counter_sched_pkg::*;
#(
  parameter  int unsigned N  = 3,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  rr_pick_t pick;

  always_comb begin
    pick  = rr_pick(RR_MAXN'(req), N, 32'(ptr));
    valid = pick.valid;
    idx   = pick.idx[IW-1:0];
  end

endmodule

// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one W-bit up-counter between N requesters.
// Define COUNTER_SCHED_PROPS_EN to compile in the embedded safety/liveness properties.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter  int unsigned N  = 3,
  parameter  int unsigned W  = 10,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  len,
  output logic [N-1:0]    gnt,
  output logic            busy,
  output logic [W-1:0]    count,
  output logic            done,
  output logic [IW-1:0]   done_id
);

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] owner;
  logic [IW-1:0] owner_nxt;
  logic [W-1:0]  lat_len;
  logic [W-1:0]  pick_len;
  logic [IW-1:0] pick_idx;
  logic          pick_valid;

  rr_arbiter #(.N(N)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    pick_len = '0;
    for (int unsigned i = 0; i < N; i++)
      if (pick_idx == IW'(i)) pick_len = len[i*W +: W];
    owner_nxt = (owner == IW'(N-1)) ? '0 : owner + IW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      gnt     <= '0;
      busy    <= 1'b0;
      count   <= '0;
      done    <= 1'b0;
      done_id <= '0;
      ptr     <= '0;
      owner   <= '0;
      lat_len <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (pick_valid) begin
            gnt     <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
            owner   <= pick_idx;
            lat_len <= pick_len;
            count   <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (!req[owner]) begin
            // Abort: release without a done pulse, still advance priority.
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
            count <= '0;
            ptr   <= owner_nxt;
          end else if (count == lat_len) begin
            state   <= DONE;
            done    <= 1'b1;
            done_id <= owner;
          end else begin
            count <= count + W'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
          count <= '0;
          ptr   <= owner_nxt;
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
          count <= '0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef COUNTER_SCHED_PROPS_EN
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt));
  a_count_le:   assert property (@(posedge clk) disable iff (!rst) count <= lat_len);
  a_done_gnt:   assert property (@(posedge clk) disable iff (!rst) done |-> gnt[done_id]);

  for (genvar g = 0; g < N; g++) begin : g_req_props
    m_req_hold: assume property (@(posedge clk) disable iff (!rst)
      (req[g] && !(done && done_id == IW'(g))) |=> req[g]);
    a_live: assert property (@(posedge clk) disable iff (!rst)
      req[g] |-> s_eventually gnt[g]);
  end
`endif

endmodule

// File: tb/tb_counter_sched.sv
// Scoreboard bench for counter_sched (N=3, W=4): expected runs queued at request time, checked at done.
module tb_counter_sched;

  localparam int unsigned N  = 3;
  localparam int unsigned W  = 4;
  localparam int unsigned IW = 2;

  typedef struct {
    int unsigned id;
    int unsigned len;
  } run_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*W-1:0]  len = '0;
  logic [N-1:0]    gnt;
  logic            busy;
  logic [W-1:0]    count;
  logic            done;
  logic [IW-1:0]   done_id;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  run_t        sb[$];
  int unsigned gcyc = 0;

  counter_sched #(.N(N), .W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .len     (len),
    .gnt     (gnt),
    .busy    (busy),
    .count   (count),
    .done    (done),
    .done_id (done_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and invariant monitor, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    chk("inv_onehot", 32'($onehot0(gnt)), 32'd1);
    chk("inv_busy", 32'(gnt != '0), 32'(busy));
    if (gnt == '0) chk("inv_idle_cnt", 32'(count), 32'd0);
    gcyc = (gnt != '0) ? gcyc + 1 : 0;
    if (done) begin
      chk("done_busy", 32'(busy), 32'd1);
      if (sb.size() == 0) begin
        chk("unexp_done", 32'(done_id), 32'hFFFF_FFFF);
      end else begin
        run_t e;
        e = sb.pop_front();
        chk("done_id", 32'(done_id), e.id);
        chk("done_cnt", 32'(count), e.len);
        chk("gnt_cycles", gcyc, e.len + 2);
        chk("done_gnt", 32'(gnt), 32'(1) << e.id);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int unsigned budget);
    for (int unsigned c = 0; c < budget; c++) begin
      tick();
      if (done) return;
    end
    chk("timeout_done", 32'd0, 32'd1);
  endtask

  task automatic wait_count(input int unsigned v, input int unsigned budget);
    for (int unsigned c = 0; c < budget; c++) begin
      tick();
      if (count == W'(v)) return;
    end
    chk("timeout_count", 32'd0, 32'd1);
  endtask

  task automatic push(input int unsigned id, input int unsigned l);
    run_t e;
    e.id  = id;
    e.len = l;
    sb.push_back(e);
  endtask

  initial begin
    logic [N-1:0] rr_order [4];
    rr_order[0] = 3'b001; rr_order[1] = 3'b010; rr_order[2] = 3'b100; rr_order[3] = 3'b001;

    // Reset with all requests pending, all lengths 0.
    req = 3'b111;
    repeat (3) tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    for (int unsigned k = 0; k < 4; k++) push((k == 3) ? 0 : k, 0);
    rst = 1'b1;

    // Round-robin fairness: 0,1,2,0 with one idle cycle between runs.
    for (int unsigned k = 0; k < 4; k++) begin
      tick();
      chk("rr_gnt", 32'(gnt), 32'(rr_order[k]));
      chk("rr_count", 32'(count), 32'd0);
      wait_done(4);
      if (k == 3) req = '0;
      tick();
      chk("rr_idle_gap", 32'(gnt), 32'd0);
    end
    tick();
    chk("idle_stay", 32'(gnt), 32'd0);

    // Single run, requester 1, length 4.
    len[1*W +: W] = 4'd4;
    req = 3'b010;
    push(1, 4);
    for (int unsigned k = 0; k < 6; k++) begin
      tick();
      chk("run_gnt", 32'(gnt), 32'b010);
      chk("run_count", 32'(count), (k < 5) ? k : 4);
      chk("run_done", 32'(done), (k == 5) ? 1 : 0);
    end
    req = '0;
    tick();
    chk("run_end_gnt", 32'(gnt), 32'd0);
    tick();

    // Max length, len change ignored, late request waits.
    len[0*W +: W] = 4'hF;
    req = 3'b001;
    push(0, 15);
    tick();
    chk("max_gnt", 32'(gnt), 32'b001);
    len[0*W +: W] = 4'd2;
    len[2*W +: W] = 4'd1;
    req = 3'b101;
    push(2, 1);
    for (int unsigned k = 0; k < 5; k++) begin
      tick();
      chk("late_wait", 32'(gnt), 32'b001);
    end
    wait_done(20);
    chk("max_peak", 32'(count), 32'hF);
    req = 3'b100;
    tick();
    chk("max_idle", 32'(gnt), 32'd0);
    tick();
    chk("late_gnt", 32'(gnt), 32'b100);
    wait_done(6);
    req = '0;
    repeat (2) tick();

    // Abort at count 2; ptr wraps to 0 so requester 0 wins next.
    len[2*W +: W] = 4'd5;
    len[0*W +: W] = 4'd0;
    len[1*W +: W] = 4'd0;
    req = 3'b100;
    wait_count(2, 10);
    chk("abort_pre", 32'(gnt), 32'b100);
    req = 3'b011;
    push(0, 0);
    push(1, 0);
    tick();
    chk("abort_gnt", 32'(gnt), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_cnt", 32'(count), 32'd0);
    tick();
    chk("abort_next", 32'(gnt), 32'b001);
    wait_done(4);
    req = 3'b010;
    tick();
    tick();
    chk("abort_next2", 32'(gnt), 32'b010);
    wait_done(4);
    req = '0;
    repeat (2) tick();

    // Asynchronous reset mid-run at count 7.
    len[1*W +: W] = 4'd9;
    req = 3'b010;
    wait_count(7, 12);
    rst = 1'b0;
    #1;
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_gnt", 32'(gnt), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    req = '0;
    tick();
    rst = 1'b1;
    for (int unsigned k = 0; k < 5; k++) begin
      tick();
      chk("mrst_no_done", 32'(done), 32'd0);
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
